// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative multiplier and the hazard unit
// that watches it: FSM state encoding, operand width and cycle counts.
package mult_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_ITER    = 32;
  localparam int MULT_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Magnitude of an operand. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude, so no overflow handling is needed.
  function automatic logic [MULT_WIDTH-1:0] mult_mag(
    input logic [MULT_WIDTH-1:0] v,
    input logic                  sgn
  );
    return (sgn && v[MULT_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Issue/result bundle between the EX stage and the multiplier.
// The pipeline (master) issues operands and flushes; the multiplier
// (slave) reports occupancy, the product and the HI/LO write strobe.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               flush;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] ex_mult;
  logic               ex_multWr;
  logic               stall;

  modport master (
    output start, is_signed, op_a, op_b, flush,
    input  busy, done, ex_mult, ex_multWr, stall
  );

  modport slave (
    input  start, is_signed, op_a, op_b, flush,
    output busy, done, ex_mult, ex_multWr, stall
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier for the EX stage.
// Operands are converted to magnitudes, multiplied unsigned over 32
// iterations, then the sign is applied in a single fix-up cycle.
// The front of the pipeline is held via stall while the engine runs.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input logic         clk,
  input logic         rst,
  mult_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(MULT_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITER - 1);

  mult_state_t        state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] fixed;

  // Upper-half add with carry for this iteration, and the sign-corrected product
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
    fixed = neg ? (~acc + 1'b1) : acc;
  end

  // FSM and datapath; the product register is loaded on the edge into DONE
  // so it is already valid during the cycle the write strobe is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else if (state != IDLE && bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            mcand <= mult_mag(bus.op_a, bus.is_signed);
            mplr  <= mult_mag(bus.op_b, bus.is_signed);
            neg   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= {sum, acc[WIDTH-1:1]};
          mplr <= mplr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          acc   <= fixed;
          prod  <= fixed;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the registered state; stall also reacts
  // to a start in the issue cycle so the pipeline freezes immediately
  always_comb begin
    bus.busy      = (state == CALC) || (state == FIX);
    bus.done      = (state == DONE);
    bus.ex_multWr = (state == DONE);
    bus.ex_mult   = prod;
    bus.stall     = ((state == IDLE) && bus.start && !bus.flush) ||
                    (state == CALC) || (state == FIX);
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: a table of operand/product records run
// one by one, with per-record options for a stray second start, a flush
// or a reset part-way through, and cycle-accurate busy/stall/done checks.
module tb_mult_unit;

  typedef struct {
    bit          is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          start2_k;
    int          flush_k;
    int          rst_k;
  } vec_t;

  localparam int NVEC    = 13;
  localparam int LAST_K  = 36;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];
  logic [63:0] last_prod;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its required value
  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Issue one multiply in cycle 0 and watch cycles 0..LAST_K, counting
  // every cycle where busy/stall/strobe deviate from the required window
  task automatic applyStimulus(input vec_t v,
                               output int busy_bad, output int stall_bad,
                               output int wr_bad, output int done_k,
                               output int done_cnt, output logic [63:0] prod);
    int  end_k;
    bit  exp_busy;
    bit  exp_stall;
    busy_bad  = 0;
    stall_bad = 0;
    wr_bad    = 0;
    done_k    = 0;
    done_cnt  = 0;
    end_k = (v.flush_k != 0) ? v.flush_k : ((v.rst_k != 0) ? v.rst_k : 33);
    for (int k = 0; k <= LAST_K; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start     = 1'b1;
        bus.is_signed = v.is_signed;
        bus.op_a      = v.a;
        bus.op_b      = v.b;
      end else if (v.start2_k != 0 && k == v.start2_k) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'd3;
        bus.op_b      = 32'd3;
      end else begin
        bus.start     = 1'b0;
      end
      bus.flush = (v.flush_k != 0 && k == v.flush_k);
      rst       = (v.rst_k != 0 && k == v.rst_k);
      #1;
      exp_busy  = (k >= 1 && k <= end_k);
      exp_stall = (k <= end_k);
      if (bus.busy !== exp_busy) busy_bad++;
      if (bus.stall !== exp_stall) stall_bad++;
      if (bus.ex_multWr !== bus.done) wr_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    rst       = 1'b0;
    prod      = bus.ex_mult;
  endtask

  initial begin
    int busy_bad, stall_bad, wr_bad, done_k, done_cnt;
    logic [63:0] prod;
    logic [63:0] exp_prod;
    bit aborted;

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 0, 0, 0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 0};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 0, 0};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 10, 0, 0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0, 0, 0};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 0, 0, 0};
    vecs[7]  = '{1'b1, 32'h0000_0005, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD, 0, 0, 0};
    vecs[8]  = '{1'b0, 32'h0000_0009, 32'h0000_0009, 64'h0000_0000_0000_0051, 0, 12, 0};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 0, 0, 0};
    vecs[10] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C, 0, 0, 0};
    vecs[11] = '{1'b0, 32'h0000_007B, 32'h0000_01C8, 64'h0000_0000_0000_DB18, 0, 0, 20};
    vecs[12] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006, 0, 0, 0};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.flush     = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_busy",  {63'd0, bus.busy},      64'd0);
    checkOutput("reset_done",  {63'd0, bus.done},      64'd0);
    checkOutput("reset_wr",    {63'd0, bus.ex_multWr}, 64'd0);
    checkOutput("reset_prod",  bus.ex_mult,            64'd0);
    checkOutput("reset_stall", {63'd0, bus.stall},     64'd0);
    bus.start = 1'b1;
    #1;
    checkOutput("issue_stall", {63'd0, bus.stall}, 64'd1);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_issue_stall", {63'd0, bus.stall}, 64'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;

    last_prod = 64'd0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], busy_bad, stall_bad, wr_bad, done_k, done_cnt, prod);
      aborted  = (vecs[i].flush_k != 0) || (vecs[i].rst_k != 0);
      exp_prod = (vecs[i].flush_k != 0) ? last_prod :
                 (vecs[i].rst_k != 0)   ? 64'd0     : vecs[i].exp;
      $display("[TB] vector %0d: a=%h b=%h signed=%0b", i, vecs[i].a, vecs[i].b,
               vecs[i].is_signed);
      checkOutput($sformatf("v%0d_busy_window", i),  64'(busy_bad),  64'd0);
      checkOutput($sformatf("v%0d_stall_window", i), 64'(stall_bad), 64'd0);
      checkOutput($sformatf("v%0d_wr_eq_done", i),   64'(wr_bad),    64'd0);
      checkOutput($sformatf("v%0d_done_cycle", i),   64'(done_k),
                  aborted ? 64'd0 : 64'd34);
      checkOutput($sformatf("v%0d_done_pulses", i),  64'(done_cnt),
                  aborted ? 64'd0 : 64'd1);
      checkOutput($sformatf("v%0d_product", i),      prod, exp_prod);
      last_prod = exp_prod;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
